// File: rtl/ddr_bw_ctrl_gen_if.sv
// Register-level bundle between the DDR bandwidth sequencer, the PS config registers and the AXI masters.
// MAXLAT_REG is present only when DDR_BW_MAXLAT_EN is defined.
interface ddr_bw_ctrl_gen_if #(
   parameter int ADDR_W  = 32,
   parameter int CNT_W   = 32,
   parameter int TIMER_W = 32,
   parameter int LEN_W   = 8
);
   logic               START_REG;
   logic [1:0]         MODE_REG;
   logic [ADDR_W-1:0]  DDR_BASEADDR_REG;
   logic [ADDR_W-1:0]  STRIDE_REG;
   logic [ADDR_W-1:0]  WRAP_REG;
   logic [CNT_W-1:0]   NTRANS_REG;
   logic [LEN_W-1:0]   LEN_REG;

   logic               RSTART_REG;
   logic [ADDR_W-1:0]  RADDR_REG;
   logic [31:0]        RLENGTH_REG;
   logic               RIDLE_REG;
   logic               WSTART_REG;
   logic [ADDR_W-1:0]  WADDR_REG;
   logic [31:0]        WNBURST_REG;

   logic               BUSY_REG;
   logic               DONE_REG;
   logic [1:0]         ERR_REG;
   logic [TIMER_W-1:0] CYCLES_REG;
   logic [CNT_W-1:0]   RCNT_REG;
   logic [CNT_W-1:0]   WCNT_REG;
`ifdef DDR_BW_MAXLAT_EN
   logic [TIMER_W-1:0] MAXLAT_REG;
`endif

   modport master (
      input  START_REG, MODE_REG, DDR_BASEADDR_REG, STRIDE_REG, WRAP_REG, NTRANS_REG, LEN_REG,
      input  RIDLE_REG,
      output RSTART_REG, RADDR_REG, RLENGTH_REG, WSTART_REG, WADDR_REG, WNBURST_REG,
      output BUSY_REG, DONE_REG, ERR_REG, CYCLES_REG, RCNT_REG, WCNT_REG
`ifdef DDR_BW_MAXLAT_EN
      , output MAXLAT_REG
`endif
   );

   modport slave (
      output START_REG, MODE_REG, DDR_BASEADDR_REG, STRIDE_REG, WRAP_REG, NTRANS_REG, LEN_REG,
      output RIDLE_REG,
      input  RSTART_REG, RADDR_REG, RLENGTH_REG, WSTART_REG, WADDR_REG, WNBURST_REG,
      input  BUSY_REG, DONE_REG, ERR_REG, CYCLES_REG, RCNT_REG, WCNT_REG
`ifdef DDR_BW_MAXLAT_EN
      , input MAXLAT_REG
`endif
   );
endinterface

// File: rtl/ddr_bw_ctrl_gen.sv
// DDR bandwidth-test sequencer: issues read/write/alternating bursts to the AXI register masters and times the run.
// Define DDR_BW_MAXLAT_EN to add MAXLAT_REG (worst ISSUE-to-completion latency of the run).
module ddr_bw_ctrl_gen #(
   parameter int ADDR_W  = 32,
   parameter int CNT_W   = 32,
   parameter int TIMER_W = 32,
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst,
   ddr_bw_ctrl_gen_if.master bus
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_ISSUE, S_WAIT_BUSY, S_WAIT_IDLE, S_NEXT, S_DONE, S_ERR
   } state_t;

   state_t             r_state, w_next;
   logic               r_start_s1, r_start_s2, r_start_prev;
   logic [1:0]         r_mode;
   logic [ADDR_W-1:0]  r_base, r_stride, r_wrap, r_offset;
   logic [CNT_W-1:0]   r_ntrans, r_rcnt, r_wcnt;
   logic [LEN_W-1:0]   r_len;
   logic [TIMER_W-1:0] r_cycles;
   logic [1:0]         r_err;
   logic               r_toggle, r_wbusy, r_wlow;
   logic [TO_W-1:0]    r_wait;

   logic               w_start_rise, w_is_write, w_widle, w_idle, w_timeout, w_in_wait, w_counting;
   logic [CNT_W-1:0]   w_done_cnt;
   logic [ADDR_W-1:0]  w_offset_inc, w_offset_nxt, w_addr;
   logic [TIMER_W-1:0] w_cycles_inc;

   assign w_start_rise = r_start_s2 & ~r_start_prev;
   assign w_is_write   = (r_mode == 2'd1) | ((r_mode == 2'd2) & r_toggle);
   // The write master's completion comes back on the shared idle line; busy spans WSTART to that rise.
   assign w_widle      = ~r_wbusy | (r_wlow & bus.RIDLE_REG);
   assign w_idle       = w_is_write ? w_widle : bus.RIDLE_REG;
   assign w_timeout    = (r_wait == TO_W'(TIMEOUT - 1));
   assign w_in_wait    = (r_state == S_WAIT_BUSY) | (r_state == S_WAIT_IDLE);
   assign w_counting   = (r_state == S_ISSUE) | w_in_wait | (r_state == S_NEXT);
   assign w_done_cnt   = r_rcnt + r_wcnt;
   assign w_offset_inc = r_offset + r_stride;
   assign w_offset_nxt = ((r_wrap != '0) && (w_offset_inc >= r_wrap)) ? '0 : w_offset_inc;
   assign w_addr       = r_base + r_offset;
   assign w_cycles_inc = (&r_cycles) ? r_cycles : r_cycles + TIMER_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the synchroniser presets high so a START held across reset is not mistaken for a new edge.
         r_start_s1   <= 1'b1;
         r_start_s2   <= 1'b1;
         r_start_prev <= 1'b1;
      end else begin
         r_start_s1   <= bus.START_REG;
         r_start_s2   <= r_start_s1;
         r_start_prev <= r_start_s2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      // NOTE: default first so every path assigns w_next and no latch is inferred.
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (w_start_rise) w_next = S_ARM;
         S_ARM: begin
            if (bus.MODE_REG == 2'd3)         w_next = S_ERR;
            else if (bus.NTRANS_REG == '0)    w_next = S_DONE;
            else                              w_next = S_ISSUE;
         end
         S_ISSUE:     w_next = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (!w_idle)        w_next = S_WAIT_IDLE;
            else if (w_timeout) w_next = S_ERR;
         end
         S_WAIT_IDLE: begin
            if (w_idle)         w_next = S_NEXT;
            else if (w_timeout) w_next = S_ERR;
         end
         S_NEXT:      w_next = (w_done_cnt == r_ntrans) ? S_DONE : S_ISSUE;
         S_DONE, S_ERR: if (!r_start_s2) w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode   <= '0;
         r_base   <= '0;
         r_stride <= '0;
         r_wrap   <= '0;
         r_ntrans <= '0;
         r_len    <= '0;
         r_offset <= '0;
         r_toggle <= 1'b0;
         r_rcnt   <= '0;
         r_wcnt   <= '0;
         r_cycles <= '0;
         r_err    <= '0;
         r_wait   <= '0;
      end else begin
         if (r_state == S_ARM) begin
            r_mode   <= bus.MODE_REG;
            r_base   <= bus.DDR_BASEADDR_REG;
            r_stride <= bus.STRIDE_REG;
            r_wrap   <= bus.WRAP_REG;
            r_ntrans <= bus.NTRANS_REG;
            r_len    <= bus.LEN_REG;
            r_offset <= '0;
            r_toggle <= 1'b0;
            r_rcnt   <= '0;
            r_wcnt   <= '0;
            r_cycles <= '0;
            r_err    <= (bus.MODE_REG == 2'd3) ? 2'd1 : 2'd0;
         end
         if ((r_state == S_NEXT) && (w_next == S_ISSUE)) begin
            r_offset <= w_offset_nxt;
            if (r_mode == 2'd2) r_toggle <= ~r_toggle;
         end
         if (w_counting) r_cycles <= w_cycles_inc;
         if ((r_state == S_WAIT_IDLE) && w_idle) begin
            if (w_is_write) r_wcnt <= r_wcnt + CNT_W'(1);
            else            r_rcnt <= r_rcnt + CNT_W'(1);
         end
         if (w_in_wait && (w_next == S_ERR)) r_err <= 2'd2;
         if (w_in_wait && (w_next == r_state)) r_wait <= r_wait + TO_W'(1);
         else                                  r_wait <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wbusy <= 1'b0;
         r_wlow  <= 1'b0;
      end else if (r_state == S_ARM) begin
         r_wbusy <= 1'b0;
         r_wlow  <= 1'b0;
      end else if ((r_state == S_ISSUE) && w_is_write) begin
         r_wbusy <= 1'b1;
         r_wlow  <= 1'b0;
      end else if (r_wbusy) begin
         if (!bus.RIDLE_REG) r_wlow  <= 1'b1;
         else if (r_wlow)    r_wbusy <= 1'b0;
      end
   end

`ifdef DDR_BW_MAXLAT_EN
   logic [TIMER_W-1:0] r_lat, r_maxlat, w_lat_inc;

   assign w_lat_inc = (&r_lat) ? r_lat : r_lat + TIMER_W'(1);

   // Latency counts the ISSUE cycle through the cycle the completion is seen, inclusive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lat    <= '0;
         r_maxlat <= '0;
      end else begin
         if (r_state == S_ARM)   r_maxlat <= '0;
         if (r_state == S_ISSUE) r_lat    <= TIMER_W'(1);
         else if (w_in_wait)     r_lat    <= w_lat_inc;
         if ((r_state == S_WAIT_IDLE) && w_idle && (w_lat_inc > r_maxlat)) r_maxlat <= w_lat_inc;
      end
   end

   assign bus.MAXLAT_REG = r_maxlat;
`endif

   assign bus.RSTART_REG  = (r_state == S_ISSUE) & ~w_is_write;
   assign bus.WSTART_REG  = (r_state == S_ISSUE) &  w_is_write;
   assign bus.RADDR_REG   = w_addr;
   assign bus.WADDR_REG   = w_addr;
   assign bus.RLENGTH_REG = 32'(r_len);
   assign bus.WNBURST_REG = 32'(r_len);
   assign bus.BUSY_REG    = (r_state == S_ARM) | w_counting;
   assign bus.DONE_REG    = (r_state == S_DONE);
   assign bus.ERR_REG     = r_err;
   assign bus.CYCLES_REG  = r_cycles;
   assign bus.RCNT_REG    = r_rcnt;
   assign bus.WCNT_REG    = r_wcnt;

endmodule

// File: tb/tb_ddr_bw_ctrl_gen.sv
// Self-checking bench for ddr_bw_ctrl_gen: a behavioural master drives idle feedback, a reference model
// predicts pulse order, addresses, counts and elapsed cycles.
module tb_ddr_bw_ctrl_gen;
  localparam int ADDR_W = 32, CNT_W = 32, TIMER_W = 32, LEN_W = 8, TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  ddr_bw_ctrl_gen_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMER_W(TIMER_W), .LEN_W(LEN_W)) bus ();

  ddr_bw_ctrl_gen #(
    .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMER_W(TIMER_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Master model and pulse monitor: idle drops in the pulse cycle and rises after `hold` cycles.
  bit          stuck = 1'b0;
  int          fixed_hold = 0;
  bit          pulse_w_q[$];
  logic [31:0] pulse_a_q[$];
  logic [31:0] pulse_l_q[$];
  int          hold_q[$];
  int          both_hi = 0;

  initial begin : master
    int cnt;
    int h;
    cnt = 0;
    bus.RIDLE_REG = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.RIDLE_REG = 1'b1;
        cnt = 0;
      end else begin
        if (bus.RSTART_REG && bus.WSTART_REG) both_hi++;
        if (bus.RSTART_REG || bus.WSTART_REG) begin
          pulse_w_q.push_back(bus.WSTART_REG);
          pulse_a_q.push_back(bus.WSTART_REG ? bus.WADDR_REG : bus.RADDR_REG);
          pulse_l_q.push_back(bus.WSTART_REG ? bus.WNBURST_REG : bus.RLENGTH_REG);
          if (!stuck) begin
            h = (fixed_hold != 0) ? fixed_hold : int'($urandom_range(2, 10));
            hold_q.push_back(h);
            bus.RIDLE_REG = 1'b0;
            cnt = h;
          end
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) bus.RIDLE_REG = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic bit outs_zero();
    return (bus.RSTART_REG == 1'b0) && (bus.WSTART_REG == 1'b0) && (bus.RADDR_REG == '0) &&
           (bus.WADDR_REG == '0) && (bus.RLENGTH_REG == '0) && (bus.WNBURST_REG == '0) &&
           (bus.BUSY_REG == 1'b0) && (bus.DONE_REG == 1'b0) && (bus.ERR_REG == '0) &&
           (bus.CYCLES_REG == '0) && (bus.RCNT_REG == '0) && (bus.WCNT_REG == '0);
  endfunction

  task automatic set_cfg(input logic [1:0] mode, input logic [31:0] base, input logic [31:0] stride,
                         input logic [31:0] wrap, input logic [31:0] ntrans, input logic [7:0] len);
    bus.MODE_REG = mode;
    bus.DDR_BASEADDR_REG = base;
    bus.STRIDE_REG = stride;
    bus.WRAP_REG = wrap;
    bus.NTRANS_REG = ntrans;
    bus.LEN_REG = len;
  endtask

  task automatic end_run();
    bus.START_REG = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Full run in a legal mode, checked against the reference model built from the task arguments.
  task automatic test_run(input string name, input logic [1:0] mode, input logic [31:0] base,
                          input logic [31:0] stride, input logic [31:0] wrap,
                          input logic [31:0] ntrans, input logic [7:0] len);
    int p0, h0, b0, nr, nw, np;
    bit ok, exp_w;
    logic [31:0] off, exp_a, exp_cyc;
    p0 = pulse_w_q.size();
    h0 = hold_q.size();
    b0 = both_hi;
    @(negedge clk);
    set_cfg(mode, base, stride, wrap, ntrans, len);
    bus.START_REG = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.BUSY_REG) begin ok = 1'b1; break; end
    end
    if (ok) begin
      @(negedge clk);
      set_cfg(2'd3, $urandom, $urandom, $urandom, '0, 8'hFF);
      ok = !bus.BUSY_REG;
      for (int k = 0; k < 3000 && !ok; k++) begin
        @(negedge clk);
        if (!bus.BUSY_REG) ok = 1'b1;
      end
    end
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL %s run_bound: got no completion, required BUSY rise and fall", name); end

    np = pulse_w_q.size() - p0;
    n_cmp++;
    if (np != int'(ntrans)) begin n_err++; $display("FAIL %s pulses: got %0d required %0d", name, np, ntrans); end

    off = '0; nr = 0; nw = 0; exp_cyc = '0;
    for (int i = 0; i < int'(ntrans); i++) begin
      exp_w = (mode == 2'd1) || ((mode == 2'd2) && (i % 2 == 1));
      exp_a = base + off;
      if (p0 + i < pulse_w_q.size()) begin
        n_cmp++;
        if (pulse_w_q[p0+i] !== exp_w) begin
          n_err++; $display("FAIL %s kind[%0d]: got write=%0b required write=%0b", name, i, pulse_w_q[p0+i], exp_w);
        end
        n_cmp++;
        if (pulse_a_q[p0+i] !== exp_a) begin
          n_err++; $display("FAIL %s addr[%0d]: got %h required %h", name, i, pulse_a_q[p0+i], exp_a);
        end
        n_cmp++;
        if (pulse_l_q[p0+i] !== 32'(len)) begin
          n_err++; $display("FAIL %s len[%0d]: got %0d required %0d", name, i, pulse_l_q[p0+i], len);
        end
      end
      if (exp_w) nw++; else nr++;
      // Each transaction: issue cycle, busy seen, hold-1 cycles waiting, one bookkeeping cycle.
      if (h0 + i < hold_q.size()) exp_cyc += 32'(hold_q[h0+i] + 2);
      off = off + stride;
      if (wrap != 0 && off >= wrap) off = '0;
    end

    n_cmp++;
    if (bus.DONE_REG !== 1'b1 || bus.ERR_REG !== 2'd0) begin
      n_err++; $display("FAIL %s status: got done=%0b err=%0d required done=1 err=0", name, bus.DONE_REG, bus.ERR_REG);
    end
    n_cmp++;
    if (bus.RCNT_REG !== 32'(nr) || bus.WCNT_REG !== 32'(nw)) begin
      n_err++; $display("FAIL %s counts: got r=%0d w=%0d required r=%0d w=%0d", name, bus.RCNT_REG, bus.WCNT_REG, nr, nw);
    end
    n_cmp++;
    if (bus.CYCLES_REG !== exp_cyc) begin
      n_err++; $display("FAIL %s cycles: got %0d required %0d", name, bus.CYCLES_REG, exp_cyc);
    end
    n_cmp++;
    if (both_hi != b0) begin
      n_err++; $display("FAIL %s both_starts: got %0d overlapping cycles required 0", name, both_hi - b0);
    end
    end_run();
    n_cmp++;
    if (bus.DONE_REG !== 1'b0 || bus.RCNT_REG !== 32'(nr) || bus.WCNT_REG !== 32'(nw)) begin
      n_err++; $display("FAIL %s retain: got done=%0b r=%0d w=%0d required done=0 r=%0d w=%0d",
                        name, bus.DONE_REG, bus.RCNT_REG, bus.WCNT_REG, nr, nw);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!outs_zero()) begin
      n_err++; $display("FAIL reset_state: got busy=%0b err=%0d cycles=%0d required all zero", bus.BUSY_REG, bus.ERR_REG, bus.CYCLES_REG);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_read_basic();
    fixed_hold = 10;
    test_run("read_basic", 2'd0, 32'h1000_0000, 32'd64, 32'd0, 32'd4, 8'd8);
    fixed_hold = 0;
  endtask

  task automatic test_alternate();
    test_run("alternate", 2'd2, 32'h2000_0040, 32'd256, 32'd0, 32'd5, 8'd16);
    test_run("write_only", 2'd1, 32'hFFFF_FFC0, 32'd64, 32'd0, 32'd3, 8'd255);
  endtask

  task automatic test_wrap();
    test_run("wrap", 2'd0, 32'h0000_8000, 32'd64, 32'd128, 32'd5, 8'd4);
    test_run("wrap_alt", 2'd2, 32'h0001_0000, 32'd96, 32'd256, 32'd6, 8'd1);
  endtask

  task automatic test_zero_trans();
    test_run("zero_trans", 2'd0, 32'h1234_0000, 32'd64, 32'd0, 32'd0, 8'd8);
  endtask

  task automatic test_illegal_mode();
    int p0, k;
    p0 = pulse_w_q.size();
    @(negedge clk);
    set_cfg(2'd3, 32'h1000_0000, 32'd64, 32'd0, 32'd4, 8'd8);
    bus.START_REG = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.ERR_REG == 2'd1) begin k = i; break; end
    end
    n_cmp++;
    if (k != 4) begin n_err++; $display("FAIL illegal_latency: got ERR=1 at negedge %0d required 4", k); end
    n_cmp++;
    if (bus.DONE_REG !== 1'b0 || bus.BUSY_REG !== 1'b0) begin
      n_err++; $display("FAIL illegal_status: got done=%0b busy=%0b required 0/0", bus.DONE_REG, bus.BUSY_REG);
    end
    end_run();
    n_cmp++;
    if (pulse_w_q.size() != p0 || bus.ERR_REG !== 2'd1) begin
      n_err++; $display("FAIL illegal_pulses: got %0d pulses err=%0d required 0 pulses err=1", pulse_w_q.size() - p0, bus.ERR_REG);
    end
  endtask

  task automatic test_timeout();
    int p0, k;
    bit seen;
    stuck = 1'b1;
    p0 = pulse_w_q.size();
    @(negedge clk);
    set_cfg(2'd0, 32'h4000_0000, 32'd64, 32'd0, 32'd3, 8'd8);
    bus.START_REG = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.RSTART_REG) begin seen = 1'b1; break; end
    end
    k = 0;
    if (seen) begin
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (bus.ERR_REG != 2'd0) begin k = i; break; end
      end
    end
    n_cmp++;
    if (k != TIMEOUT + 1) begin n_err++; $display("FAIL timeout_latency: got ERR at %0d cycles after pulse required %0d", k, TIMEOUT + 1); end
    n_cmp++;
    if (bus.ERR_REG !== 2'd2 || bus.DONE_REG !== 1'b0 || bus.BUSY_REG !== 1'b0) begin
      n_err++; $display("FAIL timeout_status: got err=%0d done=%0b busy=%0b required 2/0/0", bus.ERR_REG, bus.DONE_REG, bus.BUSY_REG);
    end
    n_cmp++;
    if (pulse_w_q.size() - p0 != 1) begin n_err++; $display("FAIL timeout_pulses: got %0d required 1", pulse_w_q.size() - p0); end
    stuck = 1'b0;
    end_run();
    test_run("rerun_after_timeout", 2'd2, 32'h4000_0000, 32'd64, 32'd0, 32'd3, 8'd8);
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    fixed_hold = 10;
    @(negedge clk);
    set_cfg(2'd0, 32'h5000_0000, 32'd64, 32'd0, 32'd4, 8'd8);
    bus.START_REG = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.RSTART_REG) begin seen = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (!seen || bus.BUSY_REG !== 1'b1) begin n_err++; $display("FAIL midrun_busy: got busy=%0b required 1", bus.BUSY_REG); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (!outs_zero()) begin
      n_err++; $display("FAIL midrun_reset: got busy=%0b cycles=%0d addr=%h required all zero", bus.BUSY_REG, bus.CYCLES_REG, bus.RADDR_REG);
    end
    fixed_hold = 0;
    repeat (2) @(negedge clk);
    bus.START_REG = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_start_held();
    int p0;
    bit busy_seen;
    p0 = pulse_w_q.size();
    @(negedge clk);
    set_cfg(2'd0, 32'h6000_0000, 32'd64, 32'd0, 32'd2, 8'd8);
    bus.START_REG = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    busy_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.BUSY_REG) busy_seen = 1'b1;
    end
    n_cmp++;
    if (busy_seen || pulse_w_q.size() != p0) begin
      n_err++; $display("FAIL start_held: got busy_seen=%0b pulses=%0d required 0/0", busy_seen, pulse_w_q.size() - p0);
    end
    end_run();
    test_run("after_held_start", 2'd0, 32'h6000_0000, 32'd64, 32'd0, 32'd2, 8'd8);
  endtask

  task automatic test_random();
    logic [1:0]  mode;
    logic [31:0] base, stride, wrap, ntrans;
    logic [7:0]  len;
    for (int it = 0; it < 6; it++) begin
      mode   = 2'($urandom_range(0, 2));
      base   = $urandom & 32'hFFFF_FFC0;
      stride = 32'($urandom_range(0, 8) * 64);
      wrap   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 8) * 64) : 32'd0;
      ntrans = 32'($urandom_range(1, 7));
      len    = 8'($urandom_range(0, 255));
      test_run($sformatf("random%0d", it), mode, base, stride, wrap, ntrans, len);
    end
  endtask

  initial begin : main
    bus.START_REG = 1'b0;
    set_cfg(2'd0, '0, '0, '0, '0, '0);
    test_reset();
    test_read_basic();
    test_alternate();
    test_wrap();
    test_zero_trans();
    test_illegal_mode();
    test_timeout();
    test_reset_mid_run();
    test_reset_start_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
